// File: rtl/data_mem.sv
// data_mem: word-organised data memory for the single-cycle MIPS datapath.
// Byte address comes from the ALU result, store data from rt. Supports word, half and byte
// stores via byte-lane merge, and word/half/byte loads with sign or zero extension.
// Reads are combinational; stores commit on the rising clock edge.
// Optional feature macro: DM_ALIGN_CHECK_EN enables misalignment / reserved-op detection
// (addr_exc), which suppresses the store and forces rdata to zero for the offending access.
// Without the macro, low address bits are ignored for alignment and reserved ops act as word ops.
module data_mem #(
  parameter int unsigned ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic [2:0]  mem_op,
  output logic [31:0] rdata,
  output logic        addr_exc
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] OP_WORD = 3'd0;
  localparam logic [2:0] OP_LH   = 3'd1;
  localparam logic [2:0] OP_LHU  = 3'd2;
  localparam logic [2:0] OP_LB   = 3'd3;
  localparam logic [2:0] OP_LBU  = 3'd4;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       offset;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              half_hi;
  logic [31:0]       cur_word;
  logic [15:0]       cur_half;
  logic [7:0]        cur_byte;
  logic [31:0]       load_val;
  logic [31:0]       merged_word;
  logic              do_store;
  logic              unused_offset;

  // Upper offset bits are dropped so out-of-range addresses wrap modulo depth.
  assign offset        = addr - BASE;
  assign idx           = offset[ADDR_W+1:2];
  assign unused_offset = ^{offset[31:ADDR_W+2], offset[1:0]};
  assign lane          = addr[1:0];
  assign half_hi       = addr[1];
  assign cur_word      = mem[idx];

`ifdef DM_ALIGN_CHECK_EN
  // Flag misaligned word/half accesses and reserved op codes.
  always_comb begin
    addr_exc = 1'b0;
    unique case (mem_op)
      OP_WORD:        addr_exc = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU:  addr_exc = addr[0];
      OP_LB, OP_LBU:  addr_exc = 1'b0;
      default:        addr_exc = 1'b1;
    endcase
  end
`else
  assign addr_exc = 1'b0;
`endif

  assign do_store = mem_write && !addr_exc;

  // Select the addressed half and byte of the current word.
  always_comb begin
    cur_half = half_hi ? cur_word[31:16] : cur_word[15:0];
    cur_byte = cur_word[7:0];
    unique case (lane)
      2'd0: cur_byte = cur_word[7:0];
      2'd1: cur_byte = cur_word[15:8];
      2'd2: cur_byte = cur_word[23:16];
      2'd3: cur_byte = cur_word[31:24];
      default: cur_byte = cur_word[7:0];
    endcase
  end

  // Load path: extend the selected field according to mem_op.
  always_comb begin
    load_val = cur_word;
    unique case (mem_op)
      OP_LH:   load_val = {{16{cur_half[15]}}, cur_half};
      OP_LHU:  load_val = {16'h0000, cur_half};
      OP_LB:   load_val = {{24{cur_byte[7]}}, cur_byte};
      OP_LBU:  load_val = {24'h00_0000, cur_byte};
      default: load_val = cur_word;
    endcase
  end

  assign rdata = addr_exc ? 32'h0000_0000 : load_val;

  // Store path: merge the store data into the pre-edge word on the selected lanes.
  always_comb begin
    merged_word = wdata;
    unique case (mem_op)
      OP_LH, OP_LHU: begin
        merged_word = half_hi ? {wdata[15:0], cur_word[15:0]}
                              : {cur_word[31:16], wdata[15:0]};
      end
      OP_LB, OP_LBU: begin
        merged_word = cur_word;
        unique case (lane)
          2'd0: merged_word[7:0]   = wdata[7:0];
          2'd1: merged_word[15:8]  = wdata[7:0];
          2'd2: merged_word[23:16] = wdata[7:0];
          2'd3: merged_word[31:24] = wdata[7:0];
          default: merged_word[7:0] = wdata[7:0];
        endcase
      end
      default: merged_word = wdata;
    endcase
  end

  // Array update: async reset clears every word; a store on a reset edge is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0000_0000;
      end
    end else if (do_store) begin
      mem[idx] <= merged_word;
    end
  end

`ifndef SYNTHESIS
  // Store trace: logs the full merged word for every committed store.
  always @(posedge clk) begin
    if (!reset && do_store) begin
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged_word);
    end
  end
`endif

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed vector table, hand-written reset / misalignment sequences and
// randomized accesses checked against a byte-addressed reference model.
module tb_data_mem;

  localparam int unsigned ADDR_W = 10;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int unsigned NBYTES = 4 * (2 ** ADDR_W);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [2:0]  mem_op;
  logic [31:0] rdata;
  logic        addr_exc;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] bm [NBYTES];

  data_mem #(
    .ADDR_W (ADDR_W),
    .BASE   (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .addr      (addr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .mem_op    (mem_op),
    .rdata     (rdata),
    .addr_exc  (addr_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: little-endian byte array.
  function automatic int unsigned boff(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'(o % NBYTES);
  endfunction

  function automatic logic m_exc(input logic [31:0] a, input logic [2:0] op);
`ifdef DM_ALIGN_CHECK_EN
    if (op > 3'd4) return 1'b1;
    if (op == 3'd0) return a[1:0] != 2'b00;
    if (op == 3'd1 || op == 3'd2) return a[0];
    return 1'b0;
`else
    return (a[0] & 1'b0) | (op[0] & 1'b0);
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] op);
    int unsigned o, w, h;
    logic [15:0] hv;
    logic [7:0]  bv;
    if (m_exc(a, op)) return 32'h0;
    o  = boff(a);
    w  = o - (o % 4);
    h  = o - (o % 2);
    hv = {bm[h + 1], bm[h]};
    bv = bm[o];
    case (op)
      3'd1:    return 32'(signed'(hv));
      3'd2:    return {16'h0, hv};
      3'd3:    return 32'(signed'(bv));
      3'd4:    return {24'h0, bv};
      default: return {bm[w + 3], bm[w + 2], bm[w + 1], bm[w]};
    endcase
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
    int unsigned o, w, h;
    if (m_exc(a, op)) return;
    o = boff(a);
    w = o - (o % 4);
    h = o - (o % 2);
    case (op)
      3'd1, 3'd2: begin bm[h] = d[7:0]; bm[h + 1] = d[15:8]; end
      3'd3, 3'd4: bm[o] = d[7:0];
      default: begin
        bm[w] = d[7:0]; bm[w + 1] = d[15:8]; bm[w + 2] = d[23:16]; bm[w + 3] = d[31:24];
      end
    endcase
  endtask

  task automatic m_clear();
    for (int i = 0; i < NBYTES; i++) bm[i] = 8'h00;
  endtask

  // One access: drive after negedge, check pre-edge outputs, commit on posedge.
  task automatic step(input string name, input logic we, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd,
                      input logic exp_exc);
    @(negedge clk);
    mem_write = we; mem_op = op; addr = a; wdata = d; pc = pc + 32'd4;
    #1;
    chk({name, ".rdata"}, rdata, exp_rd);
    chk({name, ".exc"}, {31'b0, addr_exc}, {31'b0, exp_exc});
    @(posedge clk);
    if (we) m_store(a, op, d);
    #1;
    mem_write = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [$];

  initial begin
    reset = 1'b1; pc = 32'h0000_2ffc; addr = 32'h0; wdata = 32'h0; mem_write = 1'b0;
    mem_op = 3'd0;
    m_clear();
    #3;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_exc", {31'b0, addr_exc}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Async reset mid-cycle clears the array before the next edge.
    step("rst_sw", 1'b1, 3'd0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    @(negedge clk);
    mem_op = 3'd0; addr = 32'h0; mem_write = 1'b0;
    #1;
    chk("rst_pre", rdata, 32'hDEAD_BEEF);
    #1 reset = 1'b1;
    #1;
    chk("rst_async", rdata, 32'h0);
    mem_write = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_drop", rdata, 32'h0);
    m_clear();

    pc = 32'h0000_2ffc;
    vecs.push_back('{"sw10",     1'b1, 3'd0, 32'h10,   32'h1234_5678, 32'h0});
    vecs.push_back('{"lw10",     1'b0, 3'd0, 32'h10,   32'h0,         32'h1234_5678});
    vecs.push_back('{"sb13",     1'b1, 3'd3, 32'h13,   32'h0000_00AB, 32'h0000_0012});
    vecs.push_back('{"lw10m",    1'b0, 3'd0, 32'h10,   32'h0,         32'hAB34_5678});
    vecs.push_back('{"lb13",     1'b0, 3'd3, 32'h13,   32'h0,         32'hFFFF_FFAB});
    vecs.push_back('{"lbu13",    1'b0, 3'd4, 32'h13,   32'h0,         32'h0000_00AB});
    vecs.push_back('{"sw20",     1'b1, 3'd0, 32'h20,   32'h8001_7FFF, 32'h0});
    vecs.push_back('{"lh22",     1'b0, 3'd1, 32'h22,   32'h0,         32'hFFFF_8001});
    vecs.push_back('{"lhu22",    1'b0, 3'd2, 32'h22,   32'h0,         32'h0000_8001});
    vecs.push_back('{"lh20",     1'b0, 3'd1, 32'h20,   32'h0,         32'h0000_7FFF});
    vecs.push_back('{"lbu21",    1'b0, 3'd4, 32'h21,   32'h0,         32'h0000_007F});
    vecs.push_back('{"lb20",     1'b0, 3'd3, 32'h20,   32'h0,         32'hFFFF_FFFF});
    vecs.push_back('{"sw4a",     1'b1, 3'd0, 32'h4,    32'h1,         32'h0});
    vecs.push_back('{"sw4b_rdw", 1'b1, 3'd0, 32'h4,    32'h2,         32'h1});
    vecs.push_back('{"lw4",      1'b0, 3'd0, 32'h4,    32'h0,         32'h2});
    vecs.push_back('{"sw_wrap",  1'b1, 3'd0, 32'h1004, 32'hAAAA_5555, 32'h2});
    vecs.push_back('{"lw4_wrap", 1'b0, 3'd0, 32'h4,    32'h0,         32'hAAAA_5555});
    vecs.push_back('{"sb8",      1'b1, 3'd3, 32'h8,    32'h0000_0011, 32'h0});
    vecs.push_back('{"sbB",      1'b1, 3'd4, 32'hB,    32'h0000_0022, 32'h0});
    vecs.push_back('{"lw8",      1'b0, 3'd0, 32'h8,    32'h0,         32'h2200_0011});
    vecs.push_back('{"sh22",     1'b1, 3'd2, 32'h22,   32'h1234_BEEF, 32'h0000_8001});
    vecs.push_back('{"lw20",     1'b0, 3'd0, 32'h20,   32'h0,         32'hBEEF_7FFF});
    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].we, vecs[i].op, vecs[i].a, vecs[i].d, vecs[i].exp_rd, 1'b0);
    end

    // Misaligned word store to 0x6 (word 1 holds 0xAAAA5555).
`ifdef DM_ALIGN_CHECK_EN
    step("sw6_mis", 1'b1, 3'd0, 32'h6, 32'h55, 32'h0, 1'b1);
    step("lw4_keep", 1'b0, 3'd0, 32'h4, 32'h0, 32'hAAAA_5555, 1'b0);
    step("op5_exc", 1'b0, 3'd5, 32'h10, 32'h0, 32'h0, 1'b1);
`else
    step("sw6_mis", 1'b1, 3'd0, 32'h6, 32'h55, 32'hAAAA_5555, 1'b0);
    step("lw4_new", 1'b0, 3'd0, 32'h4, 32'h0, 32'h0000_0055, 1'b0);
    step("op5_rd", 1'b0, 3'd5, 32'h10, 32'h0, 32'hAB34_5678, 1'b0);
`endif

    // Random accesses against the byte-array model, clustered for frequent aliasing.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, d;
      logic [2:0]  op;
      logic        we;
      a  = {$urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 7)) << 12 : 32'h0,
            26'h0, 6'($urandom)} | 32'h0;
      a  = (a & 32'hFFFF_F03F);
      d  = $urandom;
      op = 3'($urandom_range(0, 7));
      we = ($urandom_range(0, 1) == 1);
      step($sformatf("rnd%0d", n), we, op, a, d, m_load(a, op), m_exc(a, op));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
